// File: rtl/mult32_seq_if.sv
// rtl/mult32_seq_if.sv - launch/result bundle between the issuing logic and mult32_seq
interface mult32_seq_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     ain;
    logic [WIDTH-1:0]     bin;
    logic [2*WIDTH-1:0]   yout;
    logic                 busy;
    logic                 done;

    // Issuing side: raises start with operands, watches busy/done/yout
    modport master (
        output start, ain, bin,
        input  yout, busy, done
    );

    // Multiplier side
    modport slave (
        input  start, ain, bin,
        output yout, busy, done
    );
endinterface

// File: rtl/mult32_seq.sv
// rtl/mult32_seq.sv - sequential unsigned shift-and-add multiplier, one multiplier bit per clock
module mult32_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,   // synchronous, active-high despite the name
    mult32_seq_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic                 start_dly_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   yout_q;
    logic                 busy_q;
    logic                 done_q;

    // Only a fresh 0->1 of start in IDLE launches; edges while busy/DONE are dropped
    logic launch;
    assign launch = bus.start && !start_dly_q && (state_q == S_IDLE);

    // Control FSM plus datapath; yout is written only on completion so it never shows partial sums
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            start_dly_q <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            yout_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            start_dly_q <= bus.start;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        mcand_q  <= {{WIDTH{1'b0}}, bus.ain};
                        mplier_q <= bus.bin;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    yout_q  <= acc_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.yout = yout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_mult32_seq.sv
// tb/tb_mult32_seq.sv - randomized self-checking bench for mult32_seq against a plain-arithmetic model
module tb_mult32_seq;
    logic clk;
    logic rst_n;

    mult32_seq_if #(.WIDTH(32)) bus ();

    mult32_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    // Count done pulses away from the active edge
    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for done after the launch edge; returns edges elapsed since E0 (41 on timeout)
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 41) begin
            tick();
            lat++;
            if (bus.done === 1'b1) break;
        end
    endtask

    // One complete operation: start low for an edge, raise it, then either hold or drop it
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input bit scramble);
        int lat;
        int d0;
        bus.start = 1'b0;
        tick();
        bus.ain   = a;
        bus.bin   = b;
        bus.start = 1'b1;
        d0 = done_cnt;
        tick();                              // E0
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        if (!hold) bus.start = 1'b0;
        if (scramble) begin
            bus.ain = $urandom;
            bus.bin = $urandom;
        end
        wait_done(lat);
        check({tag, "_lat"}, 64'(lat), 64'd33);
        check({tag, "_yout"}, bus.yout, ref_mul(a, b));
        tick();
        check({tag, "_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_ndone"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int lat;
        int d0;
        logic [31:0] ra;
        logic [31:0] rb;

        bus.start = 1'b0;
        bus.ain   = '0;
        bus.bin   = '0;

        // Reset with start toggling
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.start = ~bus.start;
            bus.ain   = 32'd3;
            bus.bin   = 32'd4;
            tick();
        end
        bus.start = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("rst_yout", bus.yout, 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_ndone", 64'(done_cnt), 64'd0);

        // Basic: start held high for 225 cycles
        bus.ain = 32'd89;
        bus.bin = 32'd33;
        bus.start = 1'b1;
        d0 = done_cnt;
        tick();                              // E0
        wait_done(lat);
        check("basic_lat", 64'(lat), 64'd33);
        check("basic_yout", bus.yout, 64'd2937);
        for (int i = lat + 1; i < 225; i++) tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("basic_ndone", 64'(done_cnt - d0), 64'd1);
        check("basic_hold", bus.yout, 64'hB79);

        // Boundaries
        run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("max_const", bus.yout, 64'hFFFF_FFFE_0000_0001);
        run_op("zero", 32'd0, 32'h1234_5678, 1'b0, 1'b0);
        check("zero_const", bus.yout, 64'd0);
        run_op("ident", 32'd1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check("ident_const", bus.yout, 64'h0000_0000_DEAD_BEEF);

        // Busy ignore: re-edge at E0+10 with new operands must be dropped
        bus.start = 1'b0;
        tick();
        bus.ain = 32'd7;
        bus.bin = 32'd6;
        bus.start = 1'b1;
        d0 = done_cnt;
        tick();                              // E0
        for (int i = 0; i < 9; i++) tick();  // after E9
        bus.start = 1'b0;
        tick();                              // E10
        bus.ain = 32'd5;
        bus.bin = 32'd5;
        bus.start = 1'b1;
        wait_done(lat);
        check("bign_lat", 64'(lat + 10), 64'd33);
        check("bign_yout", bus.yout, 64'd42);
        for (int i = 0; i < 40; i++) tick();
        check("bign_ndone", 64'(done_cnt - d0), 64'd1);
        check("bign_hold", bus.yout, 64'd42);
        run_op("fresh", 32'd5, 32'd5, 1'b0, 1'b0);

        // Reset in the middle of an operation
        bus.start = 1'b0;
        tick();
        bus.ain = 32'd1000;
        bus.bin = 32'd1000;
        bus.start = 1'b1;
        d0 = done_cnt;
        tick();                              // E0
        bus.start = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        rst_n = 1'b1;
        tick();                              // E15 resets
        rst_n = 1'b0;
        check("mrst_busy", 64'(bus.busy), 64'd0);
        check("mrst_yout", bus.yout, 64'd0);
        for (int i = 0; i < 40; i++) tick();
        check("mrst_ndone", 64'(done_cnt - d0), 64'd0);
        run_op("after_rst", 32'd1000, 32'd1000, 1'b0, 1'b0);

        // Randomized operands, scrambled after capture
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 3) ra = 32'd0;
            if (i == 7) rb = 32'hFFFF_FFFF;
            run_op($sformatf("rnd%0d", i), ra, rb, i[0], 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mult32_seq.md
Name: mult32_seq

Overview:
- Sequential unsigned 32x32 shift-and-add multiplier that produces a 64-bit product.
- A rising edge on start captures the operands. The block then iterates one multiplier bit per clock and registers the product on yout.
- Sits as a small arithmetic coprocessor: the issuing logic pulses or holds start and later samples yout or done.

Parameters:
- WIDTH, 32, operand width in bits. yout is 2*WIDTH bits wide and the iteration count equals WIDTH.

Ports:
- clk  input  1  single system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-high reset: rst_n=1 at a clk edge resets the block (the port keeps the codebase name).
- start  input  1  launch request; only its 0->1 transition is honoured.
- ain  input  WIDTH  multiplicand, unsigned.
- bin  input  WIDTH  multiplier, unsigned.
- yout  output  2*WIDTH  product register; holds the last completed result.
- busy  output  1  high while a multiplication is in progress.
- done  output  1  one-cycle pulse, asserted in the cycle yout is updated.

Behaviour:
- Reset (rst_n=1 at an edge):
  - yout=0, done=0, busy=0.
  - State goes to IDLE, internal accumulator, operand registers and counter are cleared, start_d=0.
  - Reset overrides everything, including an in-progress operation, which is aborted with no done pulse.
- Start detection:
  - start_d is a register that delays start by one cycle.
  - A launch condition is start=1, start_d=0 and state=IDLE. Holding start high therefore launches exactly once.
  - Start edges while busy or in DONE are ignored and not queued.
- States: IDLE, CALC, DONE.
- IDLE:
  - On a launch edge (E0): latch ain into mcand (2*WIDTH wide, zero-extended) and bin into mplier.
  - Clear acc (2*WIDTH) and cnt, then go to CALC with busy=1.
- CALC (edges E1..EWIDTH):
  - If mplier[0]=1, then acc <= acc + mcand (modulo 2^(2*WIDTH); no overflow is possible).
  - Then mcand <= mcand<<1, mplier <= mplier>>1 and cnt <= cnt+1.
  - After WIDTH iterations (cnt reaches WIDTH-1 on the final add), go to DONE.
- DONE (edge EWIDTH+1 = E33 for WIDTH=32):
  - yout <= acc, done=1 for exactly this cycle, busy=0, return to IDLE.
  - A new launch is accepted from the following edge.
- Latency: yout holds the new product and done=1 after edge E0+33. Throughput is at most one result per 34 cycles.
- Operands: ain and bin may change after E0 without affecting the result.
- yout holds its value between completions. It does not change at launch and shows no intermediate values.
- Unsigned arithmetic only. Zero operands still run the full 33-cycle sequence.

Test Plan:
- Reset: hold rst_n=1 for several cycles, then 0 -> yout=0, busy=0, done=0. Toggling start during reset has no effect.
- Basic: ain=89, bin=33, start held high for 225 cycles -> exactly one done pulse, 33 edges after launch; yout=2937 (0xB79) and stays 2937 after start falls.
- Max: ain=bin=0xFFFFFFFF, pulse start -> yout=0xFFFFFFFE00000001 at E0+33.
- Zero/identity:
  - ain=0, bin=0x12345678 -> yout=0.
  - ain=1, bin=0xDEADBEEF -> yout=0x00000000DEADBEEF.
  - Each gives a done pulse.
- Busy ignore: launch 7*6, then at E0+10 drop and re-raise start with ain=5, bin=5 -> single result yout=42, no second done. A fresh edge after completion gives yout=25.
- Reset mid-op: launch 1000*1000, assert rst_n at E0+15 for one cycle -> busy=0, yout=0, no done pulse. A subsequent launch gives yout=1000000.
